// File: rtl/pcg_dxsm_sched_pkg.sv
// Shared types and constants for the PCG-DXSM request scheduler.
package pcg_dxsm_sched_pkg;

  // Core datapath widths.
  localparam int PCG_SEED_W = 128;
  localparam int PCG_OUT_W  = 64;

  // Seed loaded into the core after every asynchronous reset.
  localparam logic [PCG_SEED_W-1:0] PCG_DEFAULT_SEED =
    128'h0123456789ABCDEF_FEDCBA9876543210;

  // Scheduler phases: load seed, discard warm-up steps, serve requesters.
  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_e;

  // Next round-robin index with an explicit wrap, so that a non-power-of-2
  // requester count never produces an out-of-range pointer.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    return (nxt >= n) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/pcg_dxsm_sched_if.sv
// Consumer-side bundle of the scheduler: requests, grants, random data and
// the reseed handshake.
interface pcg_dxsm_sched_if
  import pcg_dxsm_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic                  reseed;
  logic [PCG_SEED_W-1:0] seed_in;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [PCG_OUT_W-1:0]  rnd_data;
  logic                  busy;

  // Consumers raise requests and reseeds; they receive grants and data.
  modport master (
    output reseed,
    output seed_in,
    output req,
    input  gnt,
    input  rnd_data,
    input  busy
  );

  // The scheduler sees the consumer requests and drives the grant side.
  modport slave (
    input  reseed,
    input  seed_in,
    input  req,
    output gnt,
    output rnd_data,
    output busy
  );

endinterface

// File: rtl/pcg_dxsm.sv
// PCG-DXSM generator core: 128-bit LCG state with a DXSM output permutation.
// rst loads data_in as the state (synchronous); en advances one step and
// registers the permuted pre-advance state on out.
module pcg_dxsm
  import pcg_dxsm_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PCG_SEED_W-1:0] data_in,
  output logic [PCG_OUT_W-1:0]  out
);

  localparam logic [PCG_OUT_W-1:0]  CHEAP_MUL = 64'hDA942042E4DD58B5;
  localparam logic [PCG_SEED_W-1:0] LCG_MUL   = {64'h0, CHEAP_MUL};
  localparam logic [PCG_SEED_W-1:0] LCG_INC   = 128'h5851F42D4C957F2D_14057B7EF767814F;

  logic [PCG_SEED_W-1:0] state_q;
  logic [PCG_OUT_W-1:0]  out_q;

  // DXSM permutation: xorshift-multiply of the high half, scaled by the
  // (forced odd) low half.
  function automatic logic [PCG_OUT_W-1:0] dxsm(input logic [PCG_SEED_W-1:0] s);
    logic [PCG_OUT_W-1:0] hi;
    logic [PCG_OUT_W-1:0] lo;
    hi = s[PCG_SEED_W-1:PCG_OUT_W];
    lo = s[PCG_OUT_W-1:0] | 64'd1;
    hi = hi ^ (hi >> 32);
    hi = hi * CHEAP_MUL;
    hi = hi ^ (hi >> 48);
    hi = hi * lo;
    return hi;
  endfunction

  // Seed load has priority over stepping; otherwise hold the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= data_in;
      out_q   <= '0;
    end else if (en) begin
      state_q <= state_q * LCG_MUL + LCG_INC;
      out_q   <= dxsm(state_q);
    end else begin
      state_q <= state_q;
      out_q   <= out_q;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/pcg_dxsm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by the pointer, pick the
// lowest set bit, rotate the index back. Usable by any shared-core scheduler.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic                       any_o,
  output logic [NUM_REQ-1:0]         gnt_oh_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot_s;
  logic [IW-1:0]      rot_idx_s;
  logic [IW:0]        sum_s;

  // Rotate so that the pointer position becomes bit 0; the modulo keeps the
  // wrap correct for non-power-of-2 requester counts.
  always_comb begin
    rot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot_s[i] = req_i[IW'((i + int'(ptr_i)) % NUM_REQ)];
    end
  end

  // Fixed priority on the rotated vector: lowest set bit wins.
  always_comb begin
    rot_idx_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rot_idx_s = rot_s[i] ? IW'(i) : rot_idx_s;
    end
  end

  // Rotate the winning index back into requester numbering.
  always_comb begin
    any_o = |req_i;
    sum_s = {1'b0, rot_idx_s} + {1'b0, ptr_i};
    if (sum_s >= (IW + 1)'(NUM_REQ)) begin
      gnt_idx_o = IW'(sum_s - (IW + 1)'(NUM_REQ));
    end else begin
      gnt_idx_o = sum_s[IW-1:0];
    end
    if (any_o) begin
      gnt_oh_o = {{(NUM_REQ - 1){1'b0}}, 1'b1} << gnt_idx_o;
    end else begin
      gnt_oh_o = '0;
    end
  end

endmodule

// File: rtl/pcg_dxsm_sched.sv
// Shares one PCG-DXSM core among NUM_REQ requesters. Owns the seeding
// sequence (seed load, warm-up discard) and delivers one word per cycle to
// the round-robin winner with one cycle of latency.
module pcg_dxsm_sched
  import pcg_dxsm_sched_pkg::*;
#(
  parameter int                    NUM_REQ      = 4,
  parameter int                    WARMUP       = 8,
  parameter logic [PCG_SEED_W-1:0] DEFAULT_SEED = PCG_DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  pcg_dxsm_sched_if.slave       bus,
  output logic                  core_rst_o,
  output logic                  core_en_o,
  output logic [PCG_SEED_W-1:0] core_seed_o,
  input  logic [PCG_OUT_W-1:0]  core_out_i
);

  localparam int            IW        = $clog2(NUM_REQ);
  localparam logic [7:0]    WARM_INIT = 8'(WARMUP);

  sched_state_e          state_q, state_d;
  logic [7:0]            warm_cnt_q, warm_cnt_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  pend_q, pend_d;
  // One-hot form of the pending requester id; it is the grant bus directly.
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [PCG_SEED_W-1:0] seed_q, seed_d;
  logic                  busy_q, busy_d;
  logic [PCG_OUT_W-1:0]  rnd_hold_q;
  logic [PCG_OUT_W-1:0]  rnd_data_s;
  logic                  core_rst_s;
  logic                  core_en_s;

  logic                  arb_any_s;
  logic [NUM_REQ-1:0]    arb_oh_s;
  logic [IW-1:0]         arb_idx_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i     (bus.req),
    .ptr_i     (rr_ptr_q),
    .any_o     (arb_any_s),
    .gnt_oh_o  (arb_oh_s),
    .gnt_idx_o (arb_idx_s)
  );

  // Phase sequencing, core control and issue decisions.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    pend_d     = 1'b0;
    gnt_d      = '0;
    seed_d     = seed_q;
    core_rst_s = 1'b0;
    core_en_s  = 1'b0;
    case (state_q)
      ST_SEED: begin
        core_rst_s = 1'b1;
        warm_cnt_d = WARM_INIT;
        if (WARM_INIT == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WARM;
        end
      end
      ST_WARM: begin
        core_en_s  = 1'b1;
        warm_cnt_d = warm_cnt_q - 8'd1;
        if (warm_cnt_q <= 8'd1) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WARM;
        end
      end
      ST_RUN: begin
        // Reseed wins over requests: no core step in the acceptance cycle.
        if (bus.reseed) begin
          seed_d  = bus.seed_in;
          state_d = ST_SEED;
        end else if (arb_any_s) begin
          core_en_s = 1'b1;
          pend_d    = 1'b1;
          gnt_d     = arb_oh_s;
          rr_ptr_d  = IW'(rr_next(32'(arb_idx_s), NUM_REQ));
        end else begin
          core_en_s = 1'b0;
          pend_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_SEED;
      end
    endcase
    busy_d = (state_d != ST_RUN);
  end

  // Word delivered this cycle comes straight from the core's output register;
  // otherwise the last delivered word is held.
  always_comb begin
    if (pend_q) begin
      rnd_data_s = core_out_i;
    end else begin
      rnd_data_s = rnd_hold_q;
    end
  end

  // Scheduler state; reset restarts seeding and aborts any pending delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SEED;
      warm_cnt_q <= 8'd0;
      rr_ptr_q   <= '0;
      pend_q     <= 1'b0;
      gnt_q      <= '0;
      seed_q     <= DEFAULT_SEED;
      busy_q     <= 1'b1;
      rnd_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      pend_q     <= pend_d;
      gnt_q      <= gnt_d;
      seed_q     <= seed_d;
      busy_q     <= busy_d;
      rnd_hold_q <= rnd_data_s;
    end
  end

  // The seed-load pulse is held off while rst is asserted so the core only
  // sees it in the cycle after reset is released.
  assign core_rst_o   = core_rst_s & ~rst;
  assign core_en_o    = core_en_s;
  assign core_seed_o  = seed_q;
  assign bus.gnt      = gnt_q;
  assign bus.rnd_data = rnd_data_s;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_pcg_dxsm_sched.sv
// Directed bench for pcg_dxsm_sched with the real PCG-DXSM core as datapath.
module tb_pcg_dxsm_sched;
  import pcg_dxsm_sched_pkg::*;

  localparam logic [127:0] DEF_SEED = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [63:0]  R_CMUL   = 64'hDA942042E4DD58B5;
  localparam logic [127:0] R_INC    = 128'h5851F42D4C957F2D_14057B7EF767814F;

  logic         clk;
  logic         rst;
  logic         core_rst;
  logic         core_en;
  logic [127:0] core_seed;
  logic [63:0]  core_out;

  int n_assert;
  int n_fail;
  logic [127:0] mdl_s;
  logic [63:0]  first_w;
  logic [63:0]  w;
  logic [63:0]  prev_obs;

  pcg_dxsm_sched_if #(.NUM_REQ(4)) bus_if ();

  pcg_dxsm_sched #(
    .NUM_REQ      (4),
    .WARMUP       (8),
    .DEFAULT_SEED (DEF_SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .core_rst_o  (core_rst),
    .core_en_o   (core_en),
    .core_seed_o (core_seed),
    .core_out_i  (core_out)
  );

  pcg_dxsm u_core (
    .clk     (clk),
    .rst     (core_rst),
    .en      (core_en),
    .data_in (core_seed),
    .out     (core_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PCG-DXSM: output from the pre-advance state, then LCG step.
  function automatic logic [63:0] ref_out(input logic [127:0] s);
    logic [63:0] h;
    logic [63:0] l;
    h = s[127:64];
    l = s[63:0] | 64'd1;
    h = (h ^ (h >> 32)) * R_CMUL;
    h = (h ^ (h >> 48)) * l;
    return h;
  endfunction

  task automatic mdl_next(output logic [63:0] r);
    r = ref_out(mdl_s);
    mdl_s = mdl_s * {64'h0, R_CMUL} + R_INC;
  endtask

  // Seed the model and drop the 8 warm-up outputs.
  task automatic mdl_seed(input logic [127:0] s);
    logic [63:0] d;
    mdl_s = s;
    for (int i = 0; i < 8; i++) mdl_next(d);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next cycle must grant port id with the next model word.
  task automatic expect_grant(input int id, input string tag, output logic [63:0] r);
    @(posedge clk); #1;
    mdl_next(r);
    chk({tag, "_gnt"}, {124'h0, bus_if.gnt}, 128'(4'b0001 << id));
    chk({tag, "_data"}, {64'h0, bus_if.rnd_data}, {64'h0, r});
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst = 1'b0;
    bus_if.req = 4'b0000;
    bus_if.reseed = 1'b0;
    bus_if.seed_in = 128'h0;
    #1 rst = 1'b1;

    // 1: reset state, seed pulse, 8 warm-up steps, idle.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {124'h0, bus_if.gnt}, 128'h0);
    chk("rst_rnd", {64'h0, bus_if.rnd_data}, 128'h0);
    chk("rst_busy", {127'h0, bus_if.busy}, 128'h1);
    chk("rst_core_rst", {127'h0, core_rst}, 128'h0);
    chk("rst_core_en", {127'h0, core_en}, 128'h0);
    chk("rst_seed", core_seed, DEF_SEED);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("seed_core_rst", {127'h0, core_rst}, 128'h1);
    chk("seed_core_en", {127'h0, core_en}, 128'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("warm_core_rst", {127'h0, core_rst}, 128'h0);
      chk("warm_core_en", {127'h0, core_en}, 128'h1);
      chk("warm_busy", {127'h0, bus_if.busy}, 128'h1);
    end
    @(posedge clk); #1;
    chk("run_busy", {127'h0, bus_if.busy}, 128'h0);
    chk("run_core_en", {127'h0, core_en}, 128'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_gnt", {124'h0, bus_if.gnt}, 128'h0);
      chk("idle_core_en", {127'h0, core_en}, 128'h0);
    end

    // 2: port 0 for 5 cycles gets model outputs 9..13.
    mdl_seed(DEF_SEED);
    bus_if.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      expect_grant(0, "t2", w);
      if (i == 0) first_w = w;
      if (i == 4) bus_if.req = 4'b0000;
    end
    @(posedge clk); #1;
    chk("t2_gnt_off", {124'h0, bus_if.gnt}, 128'h0);
    chk("t2_hold", {64'h0, bus_if.rnd_data}, {64'h0, w});

    // 3: move pointer to 0 via port 3, then all four requesting.
    bus_if.req = 4'b1000;
    expect_grant(3, "t3_prep", w);
    bus_if.req = 4'b1111;
    prev_obs = bus_if.rnd_data;
    for (int i = 0; i < 8; i++) begin
      expect_grant(i % 4, "t3", w);
      n_assert++;
      assert (bus_if.rnd_data !== prev_obs) else begin
        n_fail++;
        $error("FAIL t3_distinct: observed %0h expected a value other than %0h", bus_if.rnd_data, prev_obs);
      end
      prev_obs = bus_if.rnd_data;
    end

    // 4: pointer to 2 via port 1, then ports 1 and 3 alternate from 3.
    bus_if.req = 4'b0010;
    expect_grant(1, "t4_prep", w);
    bus_if.req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      expect_grant((i % 2 == 0) ? 3 : 1, "t4", w);
    end
    bus_if.req = 4'b0000;
    @(posedge clk); #1;
    chk("t4_gnt_off", {124'h0, bus_if.gnt}, 128'h0);

    // 5: reseed with 1 during continuous port-0 requests.
    bus_if.req = 4'b0001;
    expect_grant(0, "t5_pre", w);
    expect_grant(0, "t5_inflight", w);
    bus_if.reseed = 1'b1;
    bus_if.seed_in = 128'h1;
    @(posedge clk); #1;
    bus_if.reseed = 1'b0;
    chk("t5_seed_busy", {127'h0, bus_if.busy}, 128'h1);
    chk("t5_seed_gnt", {124'h0, bus_if.gnt}, 128'h0);
    chk("t5_seed_core_rst", {127'h0, core_rst}, 128'h1);
    chk("t5_seed_val", core_seed, 128'h1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t5_warm_busy", {127'h0, bus_if.busy}, 128'h1);
      chk("t5_warm_gnt", {124'h0, bus_if.gnt}, 128'h0);
      if (i == 1) begin
        bus_if.reseed = 1'b1;
        bus_if.seed_in = 128'hDEAD;
      end
      if (i == 2) bus_if.reseed = 1'b0;
    end
    chk("t5_reseed_dropped", core_seed, 128'h1);
    @(posedge clk); #1;
    chk("t5_run_busy", {127'h0, bus_if.busy}, 128'h0);
    chk("t5_run_gnt", {124'h0, bus_if.gnt}, 128'h0);
    mdl_seed(128'h1);
    expect_grant(0, "t5_new", w);

    // 6: async reset mid-cycle while a word is pending.
    expect_grant(0, "t6_pre", w);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_gnt_drop", {124'h0, bus_if.gnt}, 128'h0);
    chk("t6_rnd_clr", {64'h0, bus_if.rnd_data}, 128'h0);
    chk("t6_busy", {127'h0, bus_if.busy}, 128'h1);
    chk("t6_core_en", {127'h0, core_en}, 128'h0);
    chk("t6_seed", core_seed, DEF_SEED);
    repeat (2) begin
      @(posedge clk); #1;
      chk("t6_rst_gnt", {124'h0, bus_if.gnt}, 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_core_rst", {127'h0, core_rst}, 128'h1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t6_warm_gnt", {124'h0, bus_if.gnt}, 128'h0);
    end
    @(posedge clk); #1;
    chk("t6_run_busy", {127'h0, bus_if.busy}, 128'h0);
    mdl_seed(DEF_SEED);
    expect_grant(0, "t6_restart", w);
    chk("t6_same_first", {64'h0, bus_if.rnd_data}, {64'h0, first_w});
    bus_if.req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
